// File: rtl/vx_csa_accum.sv
`default_nettype none
// vx_csa_accum: accumulates redundant (sum, carry) beats with a 4:2 compressor,
// then resolves them through a segmented multi-cycle CPA onto valid/ready. rev 1.0
module vx_csa_accum #(
  parameter int S   = 12,
  parameter int A   = 32,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  input  logic [S-1:0] in_sum,
  input  logic [S-1:0] in_carry,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [A-1:0] out_data,
  input  logic         out_ready,
  output logic         busy
);
  localparam int NSEG = A / SEG;
  localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IW-1:0] LAST_SEG = IW'(NSEG - 1);
  localparam logic [A-1:0]  SEG_MASK = A'({SEG{1'b1}});

  if (((A % SEG) != 0) || (SEG > A)) begin : g_seg_check
    $error("vx_csa_accum: A must be an exact multiple of SEG");
  end

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t        state;
  logic [A-1:0]  acc_s, acc_c, result;
  logic          pending;
  logic [IW-1:0] seg_idx;
  logic          seg_cin;

  logic [A-1:0]   x_sum, x_carry, l1_s, l1_c, nx_s, nx_c;
  logic [31:0]    seg_base;
  logic [SEG-1:0] seg_a, seg_b;
  logic [SEG:0]   seg_total;
  logic [A-1:0]   seg_ins;

  // Two cascaded 3:2 levels form the 4:2 compressor; carries past bit A-1 fall off.
  always_comb begin
    x_sum   = A'(in_sum);
    x_carry = A'(in_carry);
    l1_s    = acc_s ^ acc_c ^ x_sum;
    l1_c    = ((acc_s & acc_c) | (acc_s & x_sum) | (acc_c & x_sum)) << 1;
    nx_s    = l1_s ^ l1_c ^ x_carry;
    nx_c    = ((l1_s & l1_c) | (l1_s & x_carry) | (l1_c & x_carry)) << 1;
  end

  always_comb begin
    seg_base  = 32'(seg_idx) * 32'(SEG);
    seg_a     = SEG'(acc_s >> seg_base);
    seg_b     = SEG'(acc_c >> seg_base);
    seg_total = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, seg_cin};
    seg_ins   = (result & ~(SEG_MASK << seg_base)) | (A'(seg_total[SEG-1:0]) << seg_base);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_ACCUM;
      acc_s     <= '0;
      acc_c     <= '0;
      result    <= '0;
      pending   <= 1'b0;
      seg_idx   <= '0;
      seg_cin   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (in_valid && in_ready) begin
            acc_s   <= nx_s;
            acc_c   <= nx_c;
            pending <= 1'b1;
            if (in_last) begin
              state    <= ST_RESOLVE;
              in_ready <= 1'b0;
              seg_idx  <= '0;
              seg_cin  <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          result  <= seg_ins;
          seg_cin <= seg_total[SEG];
          seg_idx <= seg_idx + 1'b1;
          if (seg_idx == LAST_SEG) begin
            state <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          // The result is presented one cycle after the top segment lands.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            acc_s     <= '0;
            acc_c     <= '0;
            pending   <= 1'b0;
            state     <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  assign out_data = result;
  assign busy     = pending || (state != ST_ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_vx_csa_accum.sv
`default_nettype none
// tb_vx_csa_accum: directed and randomized checks of vx_csa_accum against a
// beat-sum model (plus a narrow A=16/SEG=4 instance for wrap-around).
module tb_vx_csa_accum;
  localparam int S    = 12;
  localparam int A    = 32;
  localparam int SEG  = 8;
  localparam int NSEG = A / SEG;
  localparam int A2   = 16;
  localparam int SEG2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         in_valid, in_last, in_ready, out_valid, out_ready, busy;
  logic [S-1:0] in_sum, in_carry;
  logic [A-1:0] out_data;

  logic          b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [S-1:0]  b_in_sum, b_in_carry;
  logic [A2-1:0] b_out_data;

  vx_csa_accum #(.S(S), .A(A), .SEG(SEG)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_sum(in_sum),
    .in_carry(in_carry), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  vx_csa_accum #(.S(S), .A(A2), .SEG(SEG2)) dut_w (
    .clk(clk), .resetn(resetn), .in_valid(b_in_valid), .in_sum(b_in_sum),
    .in_carry(b_in_carry), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready), .busy(b_busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_acc    = 0;
  logic run_cmp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the group value is the plain sum of accepted beats; the result
  // appears NSEG+1 edges after the last beat and holds until taken.
  logic [A-1:0] m_acc;
  logic         m_ready, m_valid, m_busy;
  int           m_cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_acc <= '0; m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
    end else if (m_ready) begin
      if (in_valid) begin
        m_acc  <= m_acc + A'(in_sum) + A'(in_carry);
        m_busy <= 1'b1;
        if (in_last) begin
          m_ready <= 1'b0;
          m_cnt   <= NSEG + 1;
        end
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1'b1;
    end else if (out_ready) begin
      m_valid <= 1'b0; m_ready <= 1'b1; m_busy <= 1'b0; m_acc <= '0;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_in_ready", 64'(in_ready), 64'(m_ready));
      chk("cmp_out_valid", 64'(out_valid), 64'(m_valid));
      chk("cmp_busy", 64'(busy), 64'(m_busy));
      if (m_valid) chk("cmp_out_data", 64'(out_data), 64'(m_acc));
    end
  end

  task automatic send(input logic [S-1:0] s, input logic [S-1:0] c, input logic last);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1; in_sum = s; in_carry = c; in_last = last;
    @(negedge clk);
    t_acc = cyc;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [A-1:0] exp, input int lat);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 64'(out_valid), 64'(1));
    if (lat >= 0) chk({name, "_latency"}, 64'(cyc - t_acc), 64'(lat));
    chk({name, "_data"}, 64'(out_data), 64'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_in_ready_after"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [A-1:0] held;
    int           n;
    resetn = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_last = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_sum = '0; b_in_carry = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    resetn = 1'b1;
    run_cmp = 1'b1;
    @(negedge clk);

    // single beat
    send(12'd5, 12'd3, 1'b1);
    get_result("t1", 32'd8, NSEG + 1);

    // three-beat group
    send(12'd100, 12'd20, 1'b0);
    chk("t2_busy_first", 64'(busy), 64'(1));
    send(12'h7FF, 12'd1, 1'b0);
    send(12'd1, 12'd0, 1'b1);
    get_result("t2", 32'd2169, NSEG + 1);
    chk("t2_busy_after", 64'(busy), 64'(0));

    // segment carry chain
    send(12'hFF, 12'h01, 1'b1);
    get_result("t3", 32'h100, NSEG + 1);
    for (int i = 0; i < 2100; i++) send(12'hFFF, 12'hFFF, (i == 2099));
    get_result("t3_long", 32'(8190 * 2100), NSEG + 1);

    // backpressure: stray in_valid pulses while the result is held
    send(12'h123, 12'h456, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    held = out_data;
    chk("t4_held_value", 64'(held), 64'(32'h579));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_sum = 12'(i * 37); in_carry = 12'hABC; in_last = 1'b1;
      @(negedge clk);
      chk("t4_hold_valid", 64'(out_valid), 64'(1));
      chk("t4_hold_data", 64'(out_data), 64'(held));
      chk("t4_hold_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0; in_last = 1'b0;
    get_result("t4", 32'h579, -1);

    // wrap-around on the narrow instance
    for (int i = 0; i < 20; i++) begin
      b_in_valid = 1'b1; b_in_sum = 12'hFFF; b_in_carry = 12'hFFF; b_in_last = (i == 19);
      @(negedge clk);
    end
    t_acc = cyc;
    b_in_valid = 1'b0; b_in_last = 1'b0;
    n = 0;
    while (!b_out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_valid", 64'(b_out_valid), 64'(1));
    chk("t5_latency", 64'(cyc - t_acc), 64'(A2 / SEG2 + 1));
    chk("t5_data", 64'(b_out_data), 64'(16'h7FD8));
    chk("t5_busy", 64'(b_busy), 64'(1));
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("t5_in_ready_after", 64'(b_in_ready), 64'(1));
    chk("t5_busy_after", 64'(b_busy), 64'(0));

    // reset during the second resolve cycle
    send(12'd123, 12'd0, 1'b1);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_in_ready", 64'(in_ready), 64'(1));
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("t6_busy_after", 64'(busy), 64'(0));
    send(12'd7, 12'd0, 1'b1);
    get_result("t6", 32'd7, NSEG + 1);

    // randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sum    = S'($urandom);
      in_carry  = S'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    run_cmp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
